bidir_port_ctrl: RTL and testbench

//  Core-side controller for a WIDTH-bit group of pad_bidirhe cells (EN=1 drives pad, DataIn floats).

---
 rtl/bidir_port_pkg.sv | 17 +
 rtl/pad_sync_chain.sv | 27 ++
 rtl/bidir_port_ctrl.sv | 151 +++++++++++++++
 tb/tb_bidir_port_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_port_pkg.sv
// Shared types and sizing helpers for the bidir pad-group controller.
package bidir_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN,
    ST_SETTLE,
    ST_RESP
  } state_e;

  // Bits needed for a down-counter that is loaded with at most max_val-1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/pad_sync_chain.sv
// Per-bit flop chain bringing pad DataIn into the core clock; freezes while hold_i=1
// so a floating pad input never enters the chain.
module pad_sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (!hold_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Core-side controller for a group of bidir pads: sequences single-beat reads and
// writes onto pad EN/DataOut with turnaround guard cycles and synchronizes DataIn.
module bidir_port_ctrl
  import bidir_port_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TURN_CYC    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [WIDTH-1:0] in_data,
  output logic             in_stable,
  input  logic [WIDTH-1:0] pad_DataIn,
  output logic [WIDTH-1:0] pad_DataOut,
  output logic [WIDTH-1:0] pad_EN
);

  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("bidir_port_ctrl: HOLD_CYC must be >= 1");
  end
  if (TURN_CYC < 1) begin : g_bad_turn
    $error("bidir_port_ctrl: TURN_CYC must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("bidir_port_ctrl: SYNC_STAGES must be >= 2");
  end

  localparam int unsigned HT_MAX  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int unsigned MAX_CYC = (HT_MAX > SYNC_STAGES) ? HT_MAX : SYNC_STAGES;
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);
  localparam int unsigned STB_W   = cnt_width(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] SYNC_LD  = CNT_W'(SYNC_STAGES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(SYNC_STAGES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STB_W-1:0] stb_cnt_q;
  logic             in_stable_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_write_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [WIDTH-1:0] pad_dout_q;
  logic [WIDTH-1:0] pad_en_q;
  logic [WIDTH-1:0] sync_data_c;
  logic             wr_done_c;

  pad_sync_chain #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .hold_i(pad_en_q[0]),
    .d_i   (pad_DataIn),
    .q_o   (sync_data_c)
  );

  // Next state and counter; the counter is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = SYNC_LD;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LD;
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write response rides on the last turnaround cycle.
  assign wr_done_c = (state_d == ST_TURN) && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      pad_en_q    <= '0;
      pad_dout_q  <= '0;
      stb_cnt_q   <= '0;
      in_stable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= wr_done_c || (state_d == ST_RESP);
      rsp_write_q <= wr_done_c;
      rsp_rdata_q <= (state_d == ST_RESP) ? sync_data_c : '0;
      pad_en_q    <= {WIDTH{state_d == ST_DRIVE}};
      if ((state_q == ST_IDLE) && (state_d == ST_DRIVE)) pad_dout_q <= req_wdata;
      // Stability counts only cycles in which the chain actually shifted.
      if (state_d == ST_DRIVE) begin
        stb_cnt_q   <= '0;
        in_stable_q <= 1'b0;
      end else if (!pad_en_q[0] && !in_stable_q) begin
        stb_cnt_q   <= stb_cnt_q + STB_W'(1);
        in_stable_q <= (stb_cnt_q == STB_LAST);
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign in_data     = sync_data_c;
  assign in_stable   = in_stable_q;
  assign pad_DataOut = pad_dout_q;
  assign pad_EN      = pad_en_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl with a behavioural pad: DataIn follows the
// external driver while EN=0 and a selectable float/echo value while EN=1.
module tb_bidir_port_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_write;
  logic [W-1:0] rsp_rdata;
  logic [W-1:0] in_data;
  logic         in_stable;
  logic [W-1:0] pad_DataIn;
  logic [W-1:0] pad_DataOut;
  logic [W-1:0] pad_EN;

  logic [W-1:0] ext_val;
  logic [W-1:0] din_when_en;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int rsp_base;

  always #5 clk = ~clk;

  assign pad_DataIn = pad_EN[0] ? din_when_en : ext_val;

  bidir_port_ctrl #(
    .WIDTH      (W),
    .HOLD_CYC   (1),
    .TURN_CYC   (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .in_data    (in_data),
    .in_stable  (in_stable),
    .pad_DataIn (pad_DataIn),
    .pad_DataOut(pad_DataOut),
    .pad_EN     (pad_EN)
  );

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_wdata   = '0;
    ext_val     = 8'h5A;
    din_when_en = 'z;

    // Reset values; chain is zero even though the pad shows 5A.
    tick();
    tick();
    chk("rst_ready",  32'(req_ready), 32'h1);
    chk("rst_rspv",   32'(rsp_valid), 32'h0);
    chk("rst_rspw",   32'(rsp_write), 32'h0);
    chk("rst_rdata",  32'(rsp_rdata), 32'h0);
    chk("rst_en",     32'(pad_EN), 32'h0);
    chk("rst_dout",   32'(pad_DataOut), 32'h0);
    chk("rst_indata", 32'(in_data), 32'h0);
    chk("rst_stable", 32'(in_stable), 32'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_stable1", 32'(in_stable), 32'h0);
    tick();
    chk("post_rst_stable2", 32'(in_stable), 32'h1);
    chk("post_rst_indata",  32'(in_data), 32'h5A);

    // Test 1 + 5: write A5 with pad input X while driven.
    din_when_en = 'x;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    chk("w1_c1_en",     32'(pad_EN), 32'hFF);
    chk("w1_c1_dout",   32'(pad_DataOut), 32'hA5);
    chk("w1_c1_ready",  32'(req_ready), 32'h0);
    chk("w1_c1_rspv",   32'(rsp_valid), 32'h0);
    chk("w1_c1_stable", 32'(in_stable), 32'h0);
    chk("w1_c1_indata", 32'(in_data), 32'h5A);
    tick();
    chk("w1_c2_en",     32'(pad_EN), 32'h0);
    chk("w1_c2_rspv",   32'(rsp_valid), 32'h0);
    chk("w1_c2_indata", 32'(in_data), 32'h5A);
    chk("w1_c2_stable", 32'(in_stable), 32'h0);
    tick();
    chk("w1_c3_en",     32'(pad_EN), 32'h0);
    chk("w1_c3_rspv",   32'(rsp_valid), 32'h1);
    chk("w1_c3_rspw",   32'(rsp_write), 32'h1);
    chk("w1_c3_rdata",  32'(rsp_rdata), 32'h0);
    chk("w1_c3_ready",  32'(req_ready), 32'h0);
    chk("w1_c3_indata", 32'(in_data), 32'h5A);
    chk("w1_c3_stable", 32'(in_stable), 32'h0);
    tick();
    chk("w1_c4_ready",  32'(req_ready), 32'h1);
    chk("w1_c4_rspv",   32'(rsp_valid), 32'h0);
    chk("w1_c4_stable", 32'(in_stable), 32'h1);

    // Test 2: external 3C, read.
    ext_val = 8'h3C;
    req_valid = 1'b1; req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("r2_c1_ready", 32'(req_ready), 32'h0);
    chk("r2_c1_en",    32'(pad_EN), 32'h0);
    chk("r2_c1_rspv",  32'(rsp_valid), 32'h0);
    tick();
    chk("r2_c2_rspv",  32'(rsp_valid), 32'h0);
    tick();
    chk("r2_c3_rspv",  32'(rsp_valid), 32'h1);
    chk("r2_c3_rspw",  32'(rsp_write), 32'h0);
    chk("r2_c3_rdata", 32'(rsp_rdata), 32'h3C);
    tick();
    chk("r2_c4_ready", 32'(req_ready), 32'h1);
    chk("r2_c4_rspv",  32'(rsp_valid), 32'h0);
    chk("r2_c4_rdata", 32'(rsp_rdata), 32'h0);

    // Test 3: req_valid held high; second write waits for IDLE.
    rsp_base = rsp_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h11;
    tick();
    chk("b3_c1_dout", 32'(pad_DataOut), 32'h11);
    req_wdata = 8'h22;
    tick();
    chk("b3_c2_dout",  32'(pad_DataOut), 32'h11);
    chk("b3_c2_ready", 32'(req_ready), 32'h0);
    tick();
    chk("b3_c3_rspv",  32'(rsp_valid), 32'h1);
    chk("b3_c3_en",    32'(pad_EN), 32'h0);
    tick();
    chk("b3_c4_ready", 32'(req_ready), 32'h1);
    chk("b3_c4_en",    32'(pad_EN), 32'h0);
    tick();
    req_valid = 1'b0;
    chk("b3_c5_en",    32'(pad_EN), 32'hFF);
    chk("b3_c5_dout",  32'(pad_DataOut), 32'h22);
    chk("b3_c5_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("b3_c7_rspv",  32'(rsp_valid), 32'h1);
    chk("b3_c7_rspw",  32'(rsp_write), 32'h1);
    tick();
    chk("b3_c8_ready", 32'(req_ready), 32'h1);
    chk("b3_pulses",   32'(rsp_cnt - rsp_base), 32'd2);

    // Test 4: reset during DRIVE discards the write.
    rsp_base = rsp_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    chk("x4_c1_en", 32'(pad_EN), 32'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("x4_c2_en",     32'(pad_EN), 32'h0);
    chk("x4_c2_dout",   32'(pad_DataOut), 32'h0);
    chk("x4_c2_rspv",   32'(rsp_valid), 32'h0);
    chk("x4_c2_ready",  32'(req_ready), 32'h1);
    chk("x4_c2_indata", 32'(in_data), 32'h0);
    chk("x4_c2_stable", 32'(in_stable), 32'h0);
    tick();
    chk("x4_c3_rspv",  32'(rsp_valid), 32'h0);
    chk("x4_c3_ready", 32'(req_ready), 32'h1);
    tick();
    chk("x4_c4_rspv",   32'(rsp_valid), 32'h0);
    chk("x4_c4_stable", 32'(in_stable), 32'h1);
    chk("x4_c4_indata", 32'(in_data), 32'h3C);
    chk("x4_pulses",    32'(rsp_cnt - rsp_base), 32'd0);

    // Test 6: write FF (pad echoes FF while driven), then read external 00.
    ext_val = 8'h00;
    din_when_en = 8'hFF;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hFF;
    tick();
    req_write = 1'b0;
    chk("b6_c1_dout", 32'(pad_DataOut), 32'hFF);
    tick();
    tick();
    chk("b6_c3_rspv", 32'(rsp_valid), 32'h1);
    chk("b6_c3_rspw", 32'(rsp_write), 32'h1);
    tick();
    chk("b6_c4_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    chk("b6_c5_ready", 32'(req_ready), 32'h0);
    chk("b6_c5_en",    32'(pad_EN), 32'h0);
    tick();
    chk("b6_c6_rspv",  32'(rsp_valid), 32'h0);
    tick();
    chk("b6_c7_rspv",   32'(rsp_valid), 32'h1);
    chk("b6_c7_rspw",   32'(rsp_write), 32'h0);
    chk("b6_c7_rdata",  32'(rsp_rdata), 32'h00);
    chk("b6_c7_indata", 32'(in_data), 32'h00);
    tick();
    chk("b6_c8_ready", 32'(req_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
